multimode_timer: RTL and testbench

//  Three-mode MM:SS timekeeper: free-running clock, stopwatch and countdown timer with alarm.
//  All three counters run concurrently; btn_mode selects which one drives the BCD display digits.

---
 rtl/multimode_timer.sv | 336 +++++++++++++++++++++++++++++++++
 tb/tb_multimode_timer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multimode_timer.sv
// -----------------------------------------------------------------------------
// multimode_timer
//   MM:SS timekeeper with three concurrently running counters: a free-running
//   clock, a stopwatch and a countdown timer with an alarm. The mode register
//   selects which counter drives the BCD display digits. Buttons arrive
//   already synchronised and debounced. Each button acts on its rising edge.
//
// Ports
//   clk        in   1  clock
//   rst        in   1  synchronous, active-high reset
//   btn_mode   in   1  rising edge advances CLOCK -> STOPWATCH -> TIMER -> CLOCK
//   btn_start  in   1  rising edge = start/pause for the shown counter
//   btn_set    in   1  rising edge = set/clear for the shown counter
//   sec_uni    out  4  BCD seconds units of the displayed counter
//   sec_dec    out  4  BCD seconds tens
//   min_uni    out  4  BCD minutes units
//   min_dec    out  4  BCD minutes tens
//   mode       out  2  0=CLOCK, 1=STOPWATCH, 2=TIMER
//   running    out  1  run status of the shown stopwatch/timer, 0 in CLOCK
//   alarm      out  1  countdown-expired alarm
// -----------------------------------------------------------------------------
module multimode_timer #(
    parameter int TICK_CYCLES = 50_000_000,
    parameter int MIN_WRAP    = 60,
    parameter int TMR_MAX_MIN = 99,
    parameter int ALARM_SECS  = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_start,
    input  logic       btn_set,
    output logic [3:0] sec_uni,
    output logic [3:0] sec_dec,
    output logic [3:0] min_uni,
    output logic [3:0] min_dec,
    output logic [1:0] mode,
    output logic       running,
    output logic       alarm
);

    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int AW = $clog2(ALARM_SECS + 1);

    localparam logic [PW-1:0] PRE_LAST     = PW'(TICK_CYCLES - 1);
    localparam logic [PW-1:0] PRE_ONE      = PW'(1);
    localparam logic [AW-1:0] ALARM_LAST   = AW'(ALARM_SECS - 1);
    localparam logic [AW-1:0] ACNT_ONE     = AW'(1);
    localparam logic [6:0]    CLK_MIN_LAST = 7'(MIN_WRAP - 1);
    localparam logic [6:0]    TMR_MIN_LAST = 7'(TMR_MAX_MIN);
    localparam logic [6:0]    SW_MIN_LAST  = 7'd99;
    localparam logic [5:0]    SEC_LAST     = 6'd59;

    typedef enum logic [1:0] {
        MODE_CLOCK     = 2'd0,
        MODE_STOPWATCH = 2'd1,
        MODE_TIMER     = 2'd2,
        MODE_INVALID   = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } run_e;

    // Modulo increment; any out-of-range value also folds back to zero.
    function automatic logic [6:0] wrap_inc(input logic [6:0] v, input logic [6:0] last);
        return (v >= last) ? 7'd0 : (v + 7'd1);
    endfunction

    // Binary 0..99 to two BCD digits {tens, units}.
    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = 4'(v / 7'd10);
        units = 4'(v % 7'd10);
        return {tens, units};
    endfunction

    // Registered state
    logic [PW-1:0] pre_r;
    logic          btn_mode_d_r, btn_start_d_r, btn_set_d_r;
    mode_e         mode_r;
    logic [6:0]    clk_min_r;
    logic [5:0]    clk_sec_r;
    run_e          sw_state_r;
    logic [6:0]    sw_min_r;
    logic [5:0]    sw_sec_r;
    run_e          tmr_state_r;
    logic [6:0]    tmr_min_r;
    logic [5:0]    tmr_sec_r;
    logic [6:0]    preset_r;
    logic          alarm_r;
    logic [AW-1:0] acnt_r;

    // Next-state / combinational
    logic          tick_s;
    logic          mode_edge_s, start_edge_s, set_edge_s, any_edge_s;
    logic          mode_ev_s, start_ev_s, set_ev_s;
    mode_e         mode_n_s;
    logic [6:0]    clk_min_n_s;
    logic [5:0]    clk_sec_n_s;
    run_e          sw_state_n_s;
    logic [6:0]    sw_min_n_s;
    logic [5:0]    sw_sec_n_s;
    run_e          tmr_state_n_s;
    logic [6:0]    tmr_min_n_s;
    logic [5:0]    tmr_sec_n_s;
    logic [6:0]    preset_n_s;
    logic          expire_s;
    logic          alarm_n_s;
    logic [AW-1:0] acnt_n_s;
    logic [6:0]    disp_min_s;
    logic [5:0]    disp_sec_s;

    assign tick_s       = (pre_r == PRE_LAST);
    assign mode_edge_s  = btn_mode  & ~btn_mode_d_r;
    assign start_edge_s = btn_start & ~btn_start_d_r;
    assign set_edge_s   = btn_set   & ~btn_set_d_r;
    assign any_edge_s   = mode_edge_s | start_edge_s | set_edge_s;

    // While the alarm sounds, a button edge only silences it and is swallowed.
    assign mode_ev_s  = mode_edge_s  & ~alarm_r;
    assign start_ev_s = start_edge_s & ~alarm_r;
    assign set_ev_s   = set_edge_s   & ~alarm_r;

    // Mode FSM next state; the unused code falls back to CLOCK.
    always_comb begin
        mode_n_s = mode_r;
        case (mode_r)
            MODE_CLOCK:     if (mode_ev_s) mode_n_s = MODE_STOPWATCH; else mode_n_s = MODE_CLOCK;
            MODE_STOPWATCH: if (mode_ev_s) mode_n_s = MODE_TIMER;     else mode_n_s = MODE_STOPWATCH;
            MODE_TIMER:     if (mode_ev_s) mode_n_s = MODE_CLOCK;     else mode_n_s = MODE_TIMER;
            default:        mode_n_s = MODE_CLOCK;
        endcase
    end

    // Clock counter: set bumps minutes first, then the tick advances seconds.
    always_comb begin
        clk_min_n_s = clk_min_r;
        clk_sec_n_s = clk_sec_r;
        if (set_ev_s && (mode_r == MODE_CLOCK)) begin
            clk_min_n_s = wrap_inc(clk_min_r, CLK_MIN_LAST);
        end else begin
            clk_min_n_s = clk_min_r;
        end
        if (tick_s) begin
            if (clk_sec_n_s == SEC_LAST) begin
                clk_sec_n_s = 6'd0;
                clk_min_n_s = wrap_inc(clk_min_n_s, CLK_MIN_LAST);
            end else begin
                clk_sec_n_s = clk_sec_n_s + 6'd1;
            end
        end else begin
            clk_sec_n_s = clk_sec_r;
        end
    end

    // Stopwatch: a set in IDLE clears, start toggles; only the post-button
    // RUN state consumes the tick.
    always_comb begin
        sw_state_n_s = sw_state_r;
        sw_min_n_s   = sw_min_r;
        sw_sec_n_s   = sw_sec_r;
        if (mode_r == MODE_STOPWATCH) begin
            if (set_ev_s && (sw_state_r == ST_IDLE)) begin
                sw_min_n_s = 7'd0;
                sw_sec_n_s = 6'd0;
            end else begin
                sw_min_n_s = sw_min_r;
            end
            if (start_ev_s) begin
                sw_state_n_s = (sw_state_r == ST_RUN) ? ST_IDLE : ST_RUN;
            end else begin
                sw_state_n_s = sw_state_r;
            end
        end else begin
            sw_state_n_s = sw_state_r;
        end
        if (tick_s && (sw_state_n_s == ST_RUN)) begin
            if (sw_sec_n_s == SEC_LAST) begin
                sw_sec_n_s = 6'd0;
                sw_min_n_s = wrap_inc(sw_min_n_s, SW_MIN_LAST);
            end else begin
                sw_sec_n_s = sw_sec_n_s + 6'd1;
            end
        end else begin
            sw_sec_n_s = sw_sec_n_s;
        end
    end

    // Countdown timer: set (IDLE only) advances the preset and reloads the
    // count; start then sees the reloaded count. Reaching 00:00 on a tick
    // stops the timer and raises expire_s on the same edge.
    always_comb begin
        tmr_state_n_s = tmr_state_r;
        tmr_min_n_s   = tmr_min_r;
        tmr_sec_n_s   = tmr_sec_r;
        preset_n_s    = preset_r;
        expire_s      = 1'b0;
        if (mode_r == MODE_TIMER) begin
            if (set_ev_s && (tmr_state_r == ST_IDLE)) begin
                preset_n_s  = wrap_inc(preset_r, TMR_MIN_LAST);
                tmr_min_n_s = preset_n_s;
                tmr_sec_n_s = 6'd0;
            end else begin
                preset_n_s = preset_r;
            end
            if (start_ev_s) begin
                if (tmr_state_r == ST_RUN) begin
                    tmr_state_n_s = ST_IDLE;
                end else if ((tmr_min_n_s != 7'd0) || (tmr_sec_n_s != 6'd0)) begin
                    tmr_state_n_s = ST_RUN;
                end else begin
                    tmr_state_n_s = ST_IDLE;
                end
            end else begin
                tmr_state_n_s = tmr_state_r;
            end
        end else begin
            tmr_state_n_s = tmr_state_r;
        end
        if (tick_s && (tmr_state_n_s == ST_RUN)) begin
            if (tmr_sec_n_s == 6'd0) begin
                tmr_sec_n_s = SEC_LAST;
                tmr_min_n_s = tmr_min_n_s - 7'd1;
            end else begin
                tmr_sec_n_s = tmr_sec_n_s - 6'd1;
            end
            if ((tmr_min_n_s == 7'd0) && (tmr_sec_n_s == 6'd0)) begin
                tmr_state_n_s = ST_IDLE;
                expire_s      = 1'b1;
            end else begin
                expire_s = 1'b0;
            end
        end else begin
            expire_s = 1'b0;
        end
    end

    // Alarm: silenced by any raw button edge or after ALARM_SECS further ticks.
    always_comb begin
        alarm_n_s = alarm_r;
        acnt_n_s  = acnt_r;
        if (alarm_r) begin
            if (any_edge_s) begin
                alarm_n_s = 1'b0;
            end else if (tick_s) begin
                if (acnt_r == ALARM_LAST) begin
                    alarm_n_s = 1'b0;
                end else begin
                    acnt_n_s = acnt_r + ACNT_ONE;
                end
            end else begin
                alarm_n_s = 1'b1;
            end
        end else begin
            alarm_n_s = 1'b0;
        end
        if (expire_s) begin
            alarm_n_s = 1'b1;
            acnt_n_s  = '0;
        end else begin
            acnt_n_s = acnt_n_s;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_r         <= '0;
            btn_mode_d_r  <= 1'b0;
            btn_start_d_r <= 1'b0;
            btn_set_d_r   <= 1'b0;
            mode_r        <= MODE_CLOCK;
            clk_min_r     <= 7'd0;
            clk_sec_r     <= 6'd0;
            sw_state_r    <= ST_IDLE;
            sw_min_r      <= 7'd0;
            sw_sec_r      <= 6'd0;
            tmr_state_r   <= ST_IDLE;
            tmr_min_r     <= 7'd0;
            tmr_sec_r     <= 6'd0;
            preset_r      <= 7'd0;
            alarm_r       <= 1'b0;
            acnt_r        <= '0;
        end else begin
            pre_r         <= tick_s ? '0 : (pre_r + PRE_ONE);
            btn_mode_d_r  <= btn_mode;
            btn_start_d_r <= btn_start;
            btn_set_d_r   <= btn_set;
            mode_r        <= mode_n_s;
            clk_min_r     <= clk_min_n_s;
            clk_sec_r     <= clk_sec_n_s;
            sw_state_r    <= sw_state_n_s;
            sw_min_r      <= sw_min_n_s;
            sw_sec_r      <= sw_sec_n_s;
            tmr_state_r   <= tmr_state_n_s;
            tmr_min_r     <= tmr_min_n_s;
            tmr_sec_r     <= tmr_sec_n_s;
            preset_r      <= preset_n_s;
            alarm_r       <= alarm_n_s;
            acnt_r        <= acnt_n_s;
        end
    end

    // Display source select and run indicator for the shown counter.
    always_comb begin
        disp_min_s = clk_min_r;
        disp_sec_s = clk_sec_r;
        running    = 1'b0;
        case (mode_r)
            MODE_STOPWATCH: begin
                disp_min_s = sw_min_r;
                disp_sec_s = sw_sec_r;
                running    = (sw_state_r == ST_RUN);
            end
            MODE_TIMER: begin
                disp_min_s = tmr_min_r;
                disp_sec_s = tmr_sec_r;
                running    = (tmr_state_r == ST_RUN);
            end
            default: begin
                disp_min_s = clk_min_r;
                disp_sec_s = clk_sec_r;
                running    = 1'b0;
            end
        endcase
    end

    assign {min_dec, min_uni} = to_bcd(disp_min_s);
    assign {sec_dec, sec_uni} = to_bcd({1'b0, disp_sec_s});
    assign mode               = mode_r;
    assign alarm              = alarm_r;

endmodule

// File: tb/tb_multimode_timer.sv
// -----------------------------------------------------------------------------
// tb_multimode_timer
//   Directed scenarios plus random button traffic against a behavioural model
//   that keeps each counter as a plain count of seconds.
// -----------------------------------------------------------------------------
module tb_multimode_timer;

    localparam int TICK       = 4;
    localparam int MIN_WRAP   = 60;
    localparam int TMR_MAX    = 99;
    localparam int ALARM_SECS = 10;

    logic       clk, rst, btn_mode, btn_start, btn_set;
    logic [3:0] sec_uni, sec_dec, min_uni, min_dec;
    logic [1:0] mode;
    logic       running, alarm;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state (counters held as total seconds)
    int m_cyc, m_clk, m_sw, m_tmr, m_pre, m_acnt, m_mode;
    bit m_sw_run, m_t_run, m_alarm, pm, ps, pt;

    multimode_timer #(
        .TICK_CYCLES(TICK),
        .MIN_WRAP   (MIN_WRAP),
        .TMR_MAX_MIN(TMR_MAX),
        .ALARM_SECS (ALARM_SECS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_mode (btn_mode),
        .btn_start(btn_start),
        .btn_set  (btn_set),
        .sec_uni  (sec_uni),
        .sec_dec  (sec_dec),
        .min_uni  (min_uni),
        .min_dec  (min_dec),
        .mode     (mode),
        .running  (running),
        .alarm    (alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] bcd4(input int mm, input int ss);
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic logic [15:0] shown();
        return {min_dec, min_uni, sec_dec, sec_uni};
    endfunction

    // Advance the model by one clock using the inputs about to be sampled.
    task automatic model_update();
        bit tick, em, es, et;
        if (rst) begin
            m_cyc = 0; m_clk = 0; m_sw = 0; m_tmr = 0; m_pre = 0; m_acnt = 0; m_mode = 0;
            m_sw_run = 0; m_t_run = 0; m_alarm = 0; pm = 0; ps = 0; pt = 0;
            return;
        end
        tick = ((m_cyc % TICK) == (TICK - 1));
        em = btn_mode && !pm;
        es = btn_start && !ps;
        et = btn_set && !pt;
        pm = btn_mode; ps = btn_start; pt = btn_set;
        if (m_alarm && (em || es || et)) begin
            m_alarm = 0; em = 0; es = 0; et = 0;
        end else if (m_alarm && tick) begin
            m_acnt++;
            if (m_acnt == ALARM_SECS) m_alarm = 0;
        end
        if (et && m_mode == 0) m_clk = (((m_clk / 60) + 1) % MIN_WRAP) * 60 + (m_clk % 60);
        if (tick) m_clk = (m_clk + 1) % (MIN_WRAP * 60);
        if (m_mode == 1) begin
            if (et && !m_sw_run) m_sw = 0;
            if (es) m_sw_run = !m_sw_run;
        end
        if (tick && m_sw_run) m_sw = (m_sw + 1) % 6000;
        if (m_mode == 2) begin
            if (et && !m_t_run) begin
                m_pre = (m_pre + 1) % (TMR_MAX + 1);
                m_tmr = m_pre * 60;
            end
            if (es) begin
                if (m_t_run) m_t_run = 0;
                else if (m_tmr != 0) m_t_run = 1;
            end
        end
        if (tick && m_t_run) begin
            m_tmr--;
            if (m_tmr == 0) begin
                m_t_run = 0; m_alarm = 1; m_acnt = 0;
            end
        end
        if (em) m_mode = (m_mode + 1) % 3;
        m_cyc++;
    endtask

    task automatic compare_all();
        int v;
        bit r;
        v = (m_mode == 1) ? m_sw : (m_mode == 2) ? m_tmr : m_clk;
        r = (m_mode == 1) ? m_sw_run : (m_mode == 2) ? m_t_run : 1'b0;
        check_val("mode", 32'(mode), 32'(m_mode));
        check_val("alarm", 32'(alarm), 32'(m_alarm));
        check_val("running", 32'(running), 32'(r));
        check_val("digits", 32'(shown()), 32'(bcd4(v / 60, v % 60)));
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic run_ticks(input int n);
        int seen = 0;
        int budget = 0;
        while (seen < n && budget < (n + 1) * TICK) begin
            if ((m_cyc % TICK) == (TICK - 1)) seen++;
            step();
            budget++;
        end
        if (seen < n) check_val("run_ticks_timeout", 32'(seen), 32'(n));
    endtask

    // One-cycle press aligned so neither press nor release cycle carries a tick.
    task automatic pulse(input int which);
        while ((m_cyc % TICK) != 0) step();
        if (which == 0) btn_mode = 1'b1;
        else if (which == 1) btn_start = 1'b1;
        else btn_set = 1'b1;
        step();
        btn_mode = 1'b0; btn_start = 1'b0; btn_set = 1'b0;
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int b;
        rst = 1'b1; btn_mode = 1'b0; btn_start = 1'b0; btn_set = 1'b0;

        // Reset and free-running clock
        step(); step();
        check_val("rst_digits", 32'(shown()), 32'h0);
        check_val("rst_mode", 32'(mode), 32'd0);
        check_val("rst_alarm", 32'(alarm), 32'd0);
        check_val("rst_running", 32'(running), 32'd0);
        rst = 1'b0;
        repeat (240) step();
        check_val("clk_1min", 32'(shown()), 32'(bcd4(1, 0)));

        // Held button gives one event; mode sequence wraps
        btn_mode = 1'b1;
        repeat (10) step();
        btn_mode = 1'b0;
        step();
        check_val("mode_hold", 32'(mode), 32'd1);
        pulse(0); pulse(0);
        check_val("mode_wrap", 32'(mode), 32'd0);
        pulse(0); pulse(0); pulse(0);
        check_val("mode_3pulse", 32'(mode), 32'd0);

        // Stopwatch
        pulse(0);
        pulse(1);
        run_ticks(75);
        check_val("sw_75", 32'(shown()), 32'(bcd4(1, 15)));
        check_val("sw_running", 32'(running), 32'd1);
        pulse(1);
        run_ticks(8);
        check_val("sw_pause", 32'(shown()), 32'(bcd4(1, 15)));
        check_val("sw_paused_run", 32'(running), 32'd0);
        pulse(2);
        check_val("sw_clear", 32'(shown()), 32'h0);

        // Countdown and alarm duration
        pulse(0);
        pulse(2); pulse(2);
        check_val("tmr_preset2", 32'(shown()), 32'(bcd4(2, 0)));
        pulse(1);
        run_ticks(119);
        check_val("tmr_0001", 32'(shown()), 32'(bcd4(0, 1)));
        check_val("tmr_no_alarm", 32'(alarm), 32'd0);
        run_ticks(1);
        check_val("tmr_expired", 32'(shown()), 32'h0);
        check_val("tmr_exp_run", 32'(running), 32'd0);
        check_val("tmr_alarm_on", 32'(alarm), 32'd1);
        run_ticks(9);
        check_val("alarm_9", 32'(alarm), 32'd1);
        run_ticks(1);
        check_val("alarm_10", 32'(alarm), 32'd0);

        // Set ignored while running; button edge silences alarm only
        do_reset();
        pulse(0); pulse(0);
        pulse(2);
        pulse(1);
        run_ticks(30);
        check_val("tmr_0030", 32'(shown()), 32'(bcd4(0, 30)));
        pulse(2);
        check_val("tmr_set_ignored", 32'(shown()), 32'(bcd4(0, 30)));
        run_ticks(30);
        check_val("tmr_alarm2", 32'(alarm), 32'd1);
        pulse(0);
        check_val("alarm_edge_clr", 32'(alarm), 32'd0);
        check_val("alarm_edge_mode", 32'(mode), 32'd2);

        // Preset wrap and start ignored at 00:00
        repeat (98) pulse(2);
        check_val("preset_99", 32'(shown()), 32'(bcd4(99, 0)));
        pulse(2);
        check_val("preset_wrap", 32'(shown()), 32'h0);
        pulse(1);
        check_val("start_zero", 32'(running), 32'd0);

        // Reset mid-countdown
        pulse(2);
        pulse(1);
        run_ticks(5);
        check_val("tmr_0055", 32'(shown()), 32'(bcd4(0, 55)));
        do_reset();
        step();
        check_val("midrst_digits", 32'(shown()), 32'h0);
        check_val("midrst_mode", 32'(mode), 32'd0);
        check_val("midrst_running", 32'(running), 32'd0);

        // Clock and stopwatch wrap
        do_reset();
        pulse(0); pulse(1); pulse(0); pulse(0);
        b = 0;
        while (m_clk != 3599 && b < 20000) begin step(); b++; end
        check_val("clk_5959", 32'(shown()), 32'(bcd4(59, 59)));
        run_ticks(1);
        check_val("clk_wrap", 32'(shown()), 32'h0);
        pulse(0);
        b = 0;
        while (m_sw != 5999 && b < 30000) begin step(); b++; end
        check_val("sw_9959", 32'(shown()), 32'(bcd4(99, 59)));
        run_ticks(1);
        check_val("sw_wrap", 32'(shown()), 32'h0);

        // Random button traffic against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) btn_mode = ~btn_mode;
            if ($urandom_range(0, 5) == 0) btn_start = ~btn_start;
            if ($urandom_range(0, 5) == 0) btn_set = ~btn_set;
            rst = ($urandom_range(0, 1499) == 0);
            step();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
